// File: rtl/sync_fifo_if.sv
// Handshake/data bundle between a sync_fifo and its producer/consumer.
// The master drives the write and read controls; the slave (the FIFO) returns data and status.
interface sync_fifo_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_valid;
  logic                  wr_request;
  logic [ADDR_WIDTH-1:0] reserve;
  logic [2:0]            wr_sync_cntrl;
  logic [2:0]            rd_sync_cntrl;
  logic                  rd_request;
  logic                  nap;
  logic [1:0]            delay_sel;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  async_empty;
  logic                  async_full;
  logic                  fifo_util;

  modport master (
    output data_in, wr_valid, reserve, wr_sync_cntrl, rd_sync_cntrl,
           rd_request, nap, delay_sel,
    input  wr_request, data_out, empty, async_empty, async_full, fifo_util
  );

  modport slave (
    input  data_in, wr_valid, reserve, wr_sync_cntrl, rd_sync_cntrl,
           rd_request, nap, delay_sel,
    output wr_request, data_out, empty, async_empty, async_full, fifo_util
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with delayed cross-pointer views (synchronizer emulation),
// a peek ("nap") read mode and a selectable 0-3 stage output pipe.
module sync_fifo #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  sync_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_tap_q [1:7];
  logic [PW-1:0] rd_tap_q [1:7];
  logic [PW-1:0] wr_tap   [0:7];
  logic [PW-1:0] rd_tap   [0:7];
  logic [PW-1:0] wr_ptr_dly, rd_ptr_dly;
  logic [PW-1:0] occ, dly_fill, used_w, free_w;
  logic [DATA_WIDTH-1:0] stage_q [0:3];
  logic          full_raw, empty_dly, wr_fire, rd_fire;

  always_comb begin
    wr_tap[0] = wr_ptr_q;
    rd_tap[0] = rd_ptr_q;
    for (int i = 1; i < 8; i++) begin
      wr_tap[i] = wr_tap_q[i];
      rd_tap[i] = rd_tap_q[i];
    end
  end

  assign wr_ptr_dly = wr_tap[bus.rd_sync_cntrl];
  assign rd_ptr_dly = rd_tap[bus.wr_sync_cntrl];

  assign occ      = wr_ptr_q - rd_ptr_q;
  assign full_raw = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                    (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  // A freshly selected older tap can sit behind rd_ptr; that wraps to a huge
  // distance and must read as empty rather than as data available.
  assign dly_fill  = wr_ptr_dly - rd_ptr_q;
  assign empty_dly = (dly_fill == '0) || (dly_fill > PW'(DEPTH));

  // Likewise an old rd_ptr view can make apparent usage exceed the depth.
  assign used_w = wr_ptr_q - rd_ptr_dly;
  assign free_w = (used_w >= PW'(DEPTH)) ? '0 : PW'(DEPTH) - used_w;

  assign wr_fire = bus.wr_valid && !full_raw;
  assign rd_fire = bus.rd_request && !empty_dly;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire)
      wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire && !bus.nap)
      rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 1; i < 8; i++) begin
        wr_tap_q[i] <= '0;
        rd_tap_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 1; i < 8; i++) begin
        wr_tap_q[i] <= wr_tap[i-1];
        rd_tap_q[i] <= rd_tap[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.data_in;
  end

  // stage0 is the registered RAM read; later stages shift unconditionally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++)
        stage_q[i] <= '0;
    end else begin
      if (rd_fire)
        stage_q[0] <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      for (int i = 1; i < 4; i++)
        stage_q[i] <= stage_q[i-1];
    end
  end

  assign bus.data_out    = stage_q[bus.delay_sel];
  assign bus.empty       = empty_dly;
  assign bus.async_empty = (wr_ptr_q == rd_ptr_q);
  assign bus.async_full  = full_raw;
  assign bus.fifo_util   = (occ >= PW'(DEPTH / 2));
  assign bus.wr_request  = (free_w > {1'b0, bus.reserve});
endmodule

// File: tb/tb_sync_fifo.sv
// Directed and constrained-random checks for sync_fifo: ordering, full/empty,
// reserve threshold, delay lines, output latency, peek reads and async reset.
module tb_sync_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_if #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) bus ();
  sync_fifo #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_flags(input string tag);
    chk({tag, "_empty"},       32'(bus.empty),       32'd1);
    chk({tag, "_async_empty"}, 32'(bus.async_empty), 32'd1);
    chk({tag, "_async_full"},  32'(bus.async_full),  32'd0);
    chk({tag, "_fifo_util"},   32'(bus.fifo_util),   32'd0);
    chk({tag, "_wr_request"},  32'(bus.wr_request),  32'd1);
    chk({tag, "_data_out"},    bus.data_out,         32'd0);
  endtask

  initial begin
    int          n_wr, n_rd, cyc;
    logic [31:0] wr_value, exp_rd;
    logic        rd_fire;

    bus.data_in = '0;  bus.wr_valid = 1'b0;  bus.reserve = '0;
    bus.wr_sync_cntrl = '0;  bus.rd_sync_cntrl = '0;
    bus.rd_request = 1'b0;  bus.nap = 1'b0;  bus.delay_sel = '0;

    #2 reset = 1'b0;
    #1 check_reset_flags("reset");
    @(negedge clk);
    reset = 1'b1;

    // 5 writes then 5 reads with zero latency settings
    for (int i = 1; i <= 5; i++) begin
      bus.data_in = 32'(i);  bus.wr_valid = 1'b1;  tick();
    end
    bus.wr_valid = 1'b0;
    chk("t1_async_empty", 32'(bus.async_empty), 32'd0);
    chk("t1_empty",       32'(bus.empty),       32'd0);
    bus.rd_request = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("t1_rd", bus.data_out, 32'(i));
    end
    bus.rd_request = 1'b0;
    chk("t1_empty_end",       32'(bus.empty),       32'd1);
    chk("t1_async_empty_end", 32'(bus.async_empty), 32'd1);
    $display("phase basic done");

    // fill to 128, drop the 129th, drain in order
    for (int i = 1; i <= 128; i++) begin
      bus.data_in = 32'(i);  bus.wr_valid = 1'b1;  tick();
    end
    chk("t2_full",      32'(bus.async_full), 32'd1);
    chk("t2_wr_req",    32'(bus.wr_request), 32'd0);
    chk("t2_util",      32'(bus.fifo_util),  32'd1);
    bus.data_in = 32'd999;  tick();
    bus.wr_valid = 1'b0;
    chk("t2_full_after_drop", 32'(bus.async_full), 32'd1);
    bus.rd_request = 1'b1;
    for (int i = 1; i <= 128; i++) begin
      tick();
      chk("t2_rd", bus.data_out, 32'(i));
    end
    chk("t2_async_empty", 32'(bus.async_empty), 32'd1);
    chk("t2_empty",       32'(bus.empty),       32'd1);
    tick();
    bus.rd_request = 1'b0;
    chk("t2_rd_when_empty", bus.data_out, 32'd128);
    $display("phase full done");

    // reserve threshold at 118 stored words
    bus.reserve = 7'd10;
    for (int i = 0; i < 118; i++) begin
      bus.data_in = 32'd1000 + 32'(i);  bus.wr_valid = 1'b1;  tick();
    end
    bus.wr_valid = 1'b0;
    chk("t3_wr_req_118", 32'(bus.wr_request), 32'd0);
    chk("t3_full_118",   32'(bus.async_full), 32'd0);
    bus.rd_request = 1'b1;  tick();  bus.rd_request = 1'b0;
    chk("t3_wr_req_117", 32'(bus.wr_request), 32'd1);
    chk("t3_rd",         bus.data_out,        32'd1000);
    chk("t3_full_117",   32'(bus.async_full), 32'd0);
    bus.rd_request = 1'b1;
    repeat (117) tick();
    bus.rd_request = 1'b0;
    chk("t3_last",        bus.data_out,         32'd1117);
    chk("t3_async_empty", 32'(bus.async_empty), 32'd1);
    bus.reserve = '0;
    $display("phase reserve done");

    // write-to-empty latency and output pipe latency
    bus.rd_sync_cntrl = 3'd5;  bus.delay_sel = 2'd3;
    bus.data_in = 32'hABCD;  bus.wr_valid = 1'b1;  tick();
    bus.wr_valid = 1'b0;
    chk("t4_async_empty", 32'(bus.async_empty), 32'd0);
    chk("t4_empty_e0",    32'(bus.empty),       32'd1);
    repeat (4) tick();
    chk("t4_empty_e4",    32'(bus.empty),       32'd1);
    tick();
    chk("t4_empty_e5",    32'(bus.empty),       32'd0);
    bus.rd_request = 1'b1;  tick();  bus.rd_request = 1'b0;
    chk("t4_dout_a0", bus.data_out, 32'd1117);
    tick();  tick();
    chk("t4_dout_a2", bus.data_out, 32'd1117);
    tick();
    chk("t4_dout_a3", bus.data_out, 32'hABCD);
    bus.rd_sync_cntrl = '0;  bus.delay_sel = '0;
    $display("phase latency done");

    // peek reads
    bus.data_in = 32'd7;  bus.wr_valid = 1'b1;  tick();
    bus.data_in = 32'd8;  tick();
    bus.wr_valid = 1'b0;
    bus.nap = 1'b1;  bus.rd_request = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_nap", bus.data_out, 32'd7);
    end
    chk("t5_not_empty", 32'(bus.async_empty), 32'd0);
    bus.nap = 1'b0;
    tick();  chk("t5_rd7", bus.data_out, 32'd7);
    tick();  chk("t5_rd8", bus.data_out, 32'd8);
    bus.rd_request = 1'b0;
    chk("t5_async_empty", 32'(bus.async_empty), 32'd1);
    $display("phase nap done");

    // random traffic with sync-delay changes mid-stream
    n_wr = 0;  n_rd = 0;  cyc = 0;
    wr_value = 32'd1;  exp_rd = 32'd1;
    while (cyc < 20000 && !(n_wr >= 1200 && n_rd == n_wr)) begin
      if (cyc % 37 == 0) begin
        bus.wr_sync_cntrl = 3'($urandom_range(7, 0));
        bus.rd_sync_cntrl = 3'($urandom_range(7, 0));
      end
      #1;
      bus.wr_valid = (n_wr < 1200) && bus.wr_request && ($urandom_range(3, 0) != 0);
      bus.data_in  = wr_value;
      if (bus.wr_valid) begin
        chk("rnd_space", 32'(bus.async_full), 32'd0);
        wr_value++;
        n_wr++;
      end
      bus.rd_request = ($urandom_range(2, 0) != 0);
      rd_fire = bus.rd_request && !bus.empty;
      tick();
      if (rd_fire) begin
        chk("rnd_data", bus.data_out, exp_rd);
        exp_rd++;
        n_rd++;
      end
      cyc++;
    end
    bus.wr_valid = 1'b0;  bus.rd_request = 1'b0;
    chk("rnd_drained", 32'(n_rd), 32'(n_wr));
    chk("rnd_volume",  32'(n_wr >= 1200), 32'd1);
    $display("phase random done: %0d words in %0d cycles", n_wr, cyc);

    // asynchronous reset with the FIFO well past half full
    bus.wr_sync_cntrl = '0;  bus.rd_sync_cntrl = '0;
    for (int i = 0; i < 70; i++) begin
      bus.data_in = 32'h5000 + 32'(i);  bus.wr_valid = 1'b1;  tick();
    end
    bus.wr_valid = 1'b0;
    bus.rd_request = 1'b1;  tick();  bus.rd_request = 1'b0;
    chk("t6_util",  32'(bus.fifo_util), 32'd1);
    chk("t6_dout",  bus.data_out,       32'h5000);
    #2 reset = 1'b0;
    #1 check_reset_flags("t6_async_reset");
    tick();
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
